// File: rtl/cpu_mem_bridge.sv
// CPU-to-memory bridge: posted-write FIFO with read forwarding, and a
// one-transaction-at-a-time sequencer onto a req/gnt/rvalid memory port.
module cpu_mem_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPUEn,
    input  logic              CPUWrEn,
    input  logic [ADDR_W-1:0] CPUAddr,
    input  logic [DATA_W-1:0] CPUData,
    output logic [DATA_W-1:0] CPUOut,
    output logic              CPUValid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wbuf_full,
    output logic              err,
    output logic [1:0]        state_dbg
);
    // Handshake: a memory transaction transfers in the cycle mem_req and mem_gnt
    // are both high; until then mem_req, mem_we, mem_addr and mem_wdata are held.
    // mem_rvalid is a one-cycle pulse with no back-pressure.
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR_REQ = 2'd1, RD_REQ = 2'd2, RD_WAIT = 2'd3} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              fifo_full, push, pop, rd_accept, rd_miss, fwd_go, rd_go, err_evt;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign fifo_full  = (count == CNT_W'(WBUF_DEPTH));
    assign pop        = (state == WR_REQ) && mem_gnt;
    assign push       = CPUWrEn && (!fifo_full || pop);
    assign rd_accept  = CPUEn && !CPUWrEn && !rd_pend;
    assign fwd_go     = rd_accept && fwd_hit;
    assign rd_miss    = rd_accept && !fwd_hit;
    assign rd_go      = rd_pend || rd_miss;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign err_evt    = (CPUWrEn && fifo_full && !pop) || (CPUEn && CPUWrEn) ||
                        (CPUEn && rd_pend) || (mem_rvalid && state != RD_WAIT);
    assign state_dbg  = state;

    // Scan from head to tail so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (CNT_W'(i) < count && fifo_addr[rd_ptr + PTR_W'(i)] == CPUAddr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[rd_ptr + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= CPUAddr;
            fifo_data[wr_ptr] <= CPUData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wbuf_full <= 1'b0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            CPUOut    <= '0;
            CPUValid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            count     <= count_next;
            wbuf_full <= (count_next == CNT_W'(WBUF_DEPTH));
            err       <= err | err_evt;
            CPUValid  <= 1'b0;
            if (fwd_go) begin
                CPUOut   <= fwd_data;
                CPUValid <= 1'b1;
            end else if (state == RD_WAIT && mem_rvalid) begin
                CPUOut   <= mem_rdata;
                CPUValid <= 1'b1;
                rd_pend  <= 1'b0;
            end
            if (rd_miss) begin
                rd_pend <= 1'b1;
                rd_addr <= CPUAddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A pending read goes out ahead of buffered writes, but never abandons a
    // write already presented on the port.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_go) state_next = RD_REQ;
                     else if (count != '0 || push) state_next = WR_REQ;
            WR_REQ:  if (pop) state_next = rd_go ? RD_REQ : IDLE;
            RD_REQ:  if (mem_gnt) state_next = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr[rd_ptr];
                mem_wdata = fifo_data[rd_ptr];
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: reset, read miss, forwarding, read
// priority, full-buffer handling, strobe conflicts and reset mid-read.
module tb_cpu_mem_bridge;
    localparam logic [1:0] S_IDLE = 2'd0, S_WR_REQ = 2'd1, S_RD_REQ = 2'd2, S_RD_WAIT = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n, CPUEn, CPUWrEn, mem_gnt, mem_rvalid;
    logic [31:0] CPUAddr, CPUData, mem_rdata;
    logic [31:0] CPUOut, mem_addr, mem_wdata;
    logic        CPUValid, mem_req, mem_we, wbuf_full, err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_q[$];

    cpu_mem_bridge dut (
        .clk(clk), .rst_n(rst_n), .CPUEn(CPUEn), .CPUWrEn(CPUWrEn),
        .CPUAddr(CPUAddr), .CPUData(CPUData), .CPUOut(CPUOut), .CPUValid(CPUValid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wbuf_full(wbuf_full), .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Granted transactions, packed as {we, addr, wdata}.
    always @(negedge clk)
        if (rst_n && mem_req && mem_gnt) mon_q.push_back({mem_we, mem_addr, mem_wdata});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic check_txns(input string tag);
        logic [64:0] got;
        while (exp_q.size() > 0) begin
            got = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
            chk(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic drain(input int n);
        mem_gnt = 1'b1;
        repeat (n) step();
        mem_gnt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; CPUEn = 1'b0; CPUWrEn = 1'b0; CPUAddr = '0; CPUData = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_cpuvalid", 65'(CPUValid), 65'(0));
        chk("rst_cpuout", 65'(CPUOut), 65'(0));
        chk("rst_mem", 65'({mem_req, mem_we, mem_addr, mem_wdata}), 65'(0));
        chk("rst_flags", 65'({wbuf_full, err}), 65'(0));
        chk("rst_state", 65'(state_dbg), 65'(S_IDLE));
        rst_n = 1'b1;

        // Read miss: gnt tied high, rvalid one cycle after gnt.
        mem_gnt = 1'b1;
        CPUEn = 1'b1; CPUAddr = 32'h10;
        step();
        CPUEn = 1'b0;
        chk("miss_req", 65'({mem_req, mem_we, mem_addr}), 65'({1'b1, 1'b0, 32'h10}));
        chk("miss_no_early_valid", 65'(CPUValid), 65'(0));
        step();
        chk("miss_wait_req_low", 65'(mem_req), 65'(0));
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        chk("miss_valid_t3", 65'(CPUValid), 65'(1));
        chk("miss_data", 65'(CPUOut), 65'(32'hDEADBEEF));
        chk("miss_err", 65'(err), 65'(0));
        step();
        chk("miss_valid_one_cycle", 65'(CPUValid), 65'(0));
        chk("miss_data_held", 65'(CPUOut), 65'(32'hDEADBEEF));
        exp_q.push_back(txn(1'b0, 32'h10, 32'h0));
        check_txns("miss_txn");

        // Forwarding: youngest of two buffered writes to 0x20.
        CPUWrEn = 1'b1; CPUAddr = 32'h20; CPUData = 32'h11;
        step();
        chk("fwd_wr_head", 65'({mem_req, mem_we, mem_addr, mem_wdata}), 65'({1'b1, 1'b1, 32'h20, 32'h11}));
        CPUData = 32'h22;
        step();
        CPUWrEn = 1'b0; CPUEn = 1'b1;
        step();
        CPUEn = 1'b0;
        chk("fwd_valid", 65'(CPUValid), 65'(1));
        chk("fwd_data_youngest", 65'(CPUOut), 65'(32'h22));
        chk("fwd_port_stable", 65'({mem_req, mem_we, mem_addr, mem_wdata}), 65'({1'b1, 1'b1, 32'h20, 32'h11}));
        step();
        chk("fwd_valid_one_cycle", 65'(CPUValid), 65'(0));
        drain(6);
        exp_q.push_back(txn(1'b1, 32'h20, 32'h11));
        exp_q.push_back(txn(1'b1, 32'h20, 32'h22));
        check_txns("fwd_txn");

        // Read priority: read 0x40 goes right after the in-flight 0x30 write, before 0x34.
        CPUWrEn = 1'b1; CPUAddr = 32'h30; CPUData = 32'h3;
        step();
        CPUAddr = 32'h34; CPUData = 32'h4;
        step();
        CPUWrEn = 1'b0; CPUEn = 1'b1; CPUAddr = 32'h40;
        step();
        CPUEn = 1'b0;
        chk("prio_no_fwd", 65'(CPUValid), 65'(0));
        chk("prio_head_held", 65'({mem_we, mem_addr}), 65'({1'b1, 32'h30}));
        mem_gnt = 1'b1;
        step();
        chk("prio_rd_after_gnt", 65'({mem_req, mem_we, mem_addr, state_dbg}), 65'({1'b1, 1'b0, 32'h40, S_RD_REQ}));
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4040;
        step();
        mem_rvalid = 1'b0;
        chk("prio_rd_data", 65'({CPUValid, CPUOut}), 65'({1'b1, 32'h4040}));
        drain(4);
        exp_q.push_back(txn(1'b1, 32'h30, 32'h3));
        exp_q.push_back(txn(1'b0, 32'h40, 32'h0));
        exp_q.push_back(txn(1'b1, 32'h34, 32'h4));
        check_txns("prio_txn");

        // Full buffer: push with same-cycle pop accepted, push without pop dropped.
        CPUWrEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CPUAddr = 32'h50 + 32'(i); CPUData = 32'h500 + 32'(i);
            step();
        end
        chk("full_after_4", 65'({wbuf_full, err}), 65'({1'b1, 1'b0}));
        CPUAddr = 32'h60; CPUData = 32'h600; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("full_push_with_pop", 65'({wbuf_full, err}), 65'({1'b1, 1'b0}));
        CPUAddr = 32'h70; CPUData = 32'h700;
        step();
        CPUWrEn = 1'b0;
        chk("full_drop_err", 65'({wbuf_full, err}), 65'({1'b1, 1'b1}));
        drain(10);
        chk("full_drained", 65'(wbuf_full), 65'(0));
        for (int i = 0; i < 4; i++) exp_q.push_back(txn(1'b1, 32'h50 + 32'(i), 32'h500 + 32'(i)));
        exp_q.push_back(txn(1'b1, 32'h60, 32'h600));
        check_txns("full_txn");
        do_reset();
        chk("err_cleared", 65'(err), 65'(0));

        // Both strobes: write taken, read ignored.
        CPUEn = 1'b1; CPUWrEn = 1'b1; CPUAddr = 32'h80; CPUData = 32'h88;
        step();
        CPUEn = 1'b0; CPUWrEn = 1'b0;
        chk("both_no_valid", 65'(CPUValid), 65'(0));
        chk("both_err", 65'(err), 65'(1));
        chk("both_write_queued", 65'({mem_req, mem_we, mem_addr, mem_wdata}), 65'({1'b1, 1'b1, 32'h80, 32'h88}));
        step();
        chk("both_no_valid_late", 65'(CPUValid), 65'(0));
        drain(3);
        exp_q.push_back(txn(1'b1, 32'h80, 32'h88));
        check_txns("both_txn");
        do_reset();

        // Reset in RD_WAIT with one write still buffered.
        CPUWrEn = 1'b1; CPUAddr = 32'hA0; CPUData = 32'h1;
        step();
        CPUAddr = 32'hA1; CPUData = 32'h2;
        step();
        CPUWrEn = 1'b0; CPUEn = 1'b1; CPUAddr = 32'h90;
        step();
        CPUEn = 1'b0; mem_gnt = 1'b1;
        step();
        step();
        mem_gnt = 1'b0;
        chk("rw_in_rd_wait", 65'({state_dbg, mem_req}), 65'({S_RD_WAIT, 1'b0}));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_after_rst", 65'({mem_req, CPUValid, wbuf_full, err, state_dbg}), 65'({4'b0, S_IDLE}));
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step();
        mem_rvalid = 1'b0;
        chk("rw_late_rvalid_ignored", 65'(CPUValid), 65'(0));
        chk("rw_late_rvalid_err", 65'(err), 65'(1));
        CPUWrEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CPUAddr = 32'hB0 + 32'(i); CPUData = 32'(i);
            step();
        end
        chk("rw_count_cleared", 65'(wbuf_full), 65'(0));
        CPUAddr = 32'hB3;
        step();
        CPUWrEn = 1'b0;
        chk("rw_full_at_4", 65'(wbuf_full), 65'(1));
        exp_q.push_back(txn(1'b1, 32'hA0, 32'h1));
        exp_q.push_back(txn(1'b0, 32'h90, 32'h0));
        check_txns("rw_txn");
        chk("no_extra_txns", 65'(mon_q.size()), 65'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
